gnn_result_serializer: RTL and testbench
========================================

GNN_RESULT_SERIALIZER -- requirements
Module: gnn_result_serializer

Interface
REQ-001 Parameter: IDLE_GAP, default 0, number of idle cycles (0..15) inserted after each frame before the block re-arms.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 res_n{0..3}_o{0,1}  input  21 each (8 ports)  signed layer-2 results per node/output, from the 4-node DNN array.
REQ-005 rdy_n{0..3}_o{0,1}  input  1 each (8 ports)  per-result ready flags from the DNN array.
REQ-006 ovr_clr  input  1  synchronous clear of the overrun flag.
REQ-007 dout  output  21  signed result word on the stream.
REQ-008 dout_valid  output  1  stream word valid.
REQ-009 dout_ready  input  1  downstream accepts the word.
REQ-010 dout_idx  output  3  index of the current word (0..7).
REQ-011 dout_last  output  1  high with word 7 of a frame.
REQ-012 dout_par  output  1  even parity of dout (see Configuration).
REQ-013 busy  output  1  high in SEND or GAP.
REQ-014 overrun  output  1  sticky flag: a frame was dropped.
REQ-015 frame_cnt  output  8  count of completed frames.

Function
REQ-016 all_rdy SHALL be the AND of all 8 rdy inputs; all_rdy_q SHALL be all_rdy registered; rise SHALL be all_rdy & ~all_rdy_q.
REQ-017 FSM states SHALL be IDLE, SEND and GAP; reset state SHALL be IDLE.
REQ-018 In IDLE, a rise SHALL latch all 8 results into an internal buffer, set idx=0, and move to SEND; dout_valid SHALL assert in the following cycle (1-cycle capture latency).
REQ-019 Buffer order SHALL be: idx0=n0_o0, 1=n0_o1, 2=n1_o0, 3=n1_o1, 4=n2_o0, 5=n2_o1, 6=n3_o0, 7=n3_o1.
REQ-020 In SEND: dout_valid=1, dout=buf[idx], dout_idx=idx, dout_last=(idx==7); these outputs SHALL stay stable until dout_valid & dout_ready.
REQ-021 On a handshake with idx<7, idx SHALL increment, giving at most one word per cycle with dout_ready held high.
REQ-022 On a handshake with idx==7: frame_cnt SHALL increment, wrapping 255->0. The next state SHALL be GAP if IDLE_GAP>0, otherwise IDLE. dout_valid SHALL drop in the next cycle.
REQ-023 GAP SHALL last exactly IDLE_GAP cycles and then return to IDLE; dout_valid=0 throughout.
REQ-024 A rise while in SEND or GAP SHALL set overrun and drop that frame, with no buffer change; this includes a rise in the same cycle as the final handshake.
REQ-025 Input results SHALL be ignored outside the capture cycle; the buffer changes only on capture.
REQ-026 overrun SHALL stay set until ovr_clr=1. If ovr_clr and a new overrun occur in the same cycle, set SHALL win.
REQ-027 When not in SEND, dout, dout_idx and dout_last SHALL be 0.

Reset
REQ-028 Assertion of rst_n SHALL immediately force IDLE, and SHALL clear the buffer, idx, dout, dout_valid, dout_last, dout_idx, dout_par, busy, overrun, frame_cnt, the GAP counter and all_rdy_q to 0.
REQ-029 Reset mid-frame SHALL abort the frame with no partial completion.
REQ-030 If all_rdy=1 at reset release, the first clock SHALL see a rise and capture, because all_rdy_q resets to 0.

Configuration
REQ-031 With macro GNN_SER_PARITY_EN defined, dout_par SHALL equal the XOR of all 21 dout bits whenever dout_valid=1, and 0 otherwise.
REQ-032 Without GNN_SER_PARITY_EN, dout_par SHALL be constant 0 and no parity logic SHALL be synthesized.

Verification
REQ-033 Results 1,-2,3,-4,5,-6,7,-8 with all rdy rising and dout_ready=1 -> valid from cycle+1 for 8 consecutive cycles, dout=1..-8 in order, last on idx7, frame_cnt=1.
REQ-034 dout_ready toggling 1,0,0,1 during a frame -> dout and idx held during the stall, no word lost or duplicated, 8 handshakes total.
REQ-035 Second rise at beat 3 -> overrun=1, the frame completes with the original data, frame_cnt=1; then ovr_clr=1 -> overrun=0.
REQ-036 IDLE_GAP=3 and a rise 1 cycle after last -> overrun=1; a rise 4 cycles after last -> captured normally.
REQ-037 rst_n low at beat 5 -> all outputs 0 at once; with rdy flags still high at release -> a new frame starts from idx0.
REQ-038 With GNN_SER_PARITY_EN, dout=21'h000007 -> dout_par=1 and dout=21'h000003 -> dout_par=0; without the macro -> dout_par=0 always.

Source files
------------

// File: rtl/gnn_result_serializer_if.sv
// gnn_result_serializer_if: result stream bus (word, valid/ready handshake, index, last, parity)
//   master: drives dout, dout_valid, dout_idx, dout_last, dout_par; samples dout_ready
//   slave : samples the stream; drives dout_ready
interface gnn_result_serializer_if;
  logic signed [20:0] dout;
  logic               dout_valid;
  logic               dout_ready;
  logic [2:0]         dout_idx;
  logic               dout_last;
  logic               dout_par;
  modport master (output dout, dout_valid, dout_idx, dout_last, dout_par, input dout_ready);
  modport slave  (input dout, dout_valid, dout_idx, dout_last, dout_par, output dout_ready);
endinterface

// File: rtl/gnn_result_serializer.sv
// gnn_result_serializer: captures the 8 DNN layer-2 results on a rising all-ready and streams them out one word per handshake
//   clk, rst_n (async, active-low)
//   res_n{0..3}_o{0,1} / rdy_n{0..3}_o{0,1}: results and ready flags from the 4-node array
//   ovr_clr: clears the sticky overrun flag
//   s (master): dout/dout_valid/dout_ready/dout_idx/dout_last/dout_par stream
//   busy: frame in flight or idle gap; overrun: a frame was dropped; frame_cnt: completed frames
//   IDLE_GAP: idle cycles after each frame; macro GNN_SER_PARITY_EN enables dout_par
module gnn_result_serializer #(
  parameter int IDLE_GAP = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [20:0]       res_n0_o0,
  input  logic signed [20:0]       res_n0_o1,
  input  logic signed [20:0]       res_n1_o0,
  input  logic signed [20:0]       res_n1_o1,
  input  logic signed [20:0]       res_n2_o0,
  input  logic signed [20:0]       res_n2_o1,
  input  logic signed [20:0]       res_n3_o0,
  input  logic signed [20:0]       res_n3_o1,
  input  logic                     rdy_n0_o0,
  input  logic                     rdy_n0_o1,
  input  logic                     rdy_n1_o0,
  input  logic                     rdy_n1_o1,
  input  logic                     rdy_n2_o0,
  input  logic                     rdy_n2_o1,
  input  logic                     rdy_n3_o0,
  input  logic                     rdy_n3_o1,
  input  logic                     ovr_clr,
  output logic                     busy,
  output logic                     overrun,
  output logic [7:0]               frame_cnt,
  gnn_result_serializer_if.master  s
);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;
  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);
  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] cnt_q, cnt_d;
  logic ovr_q, ovr_d, all_rdy, all_rdy_q, rise, hs, cap;
  logic signed [20:0] wbuf_q [8];
  logic signed [20:0] wbuf_d [8];
  assign all_rdy = &{rdy_n0_o0, rdy_n0_o1, rdy_n1_o0, rdy_n1_o1, rdy_n2_o0, rdy_n2_o1, rdy_n3_o0, rdy_n3_o1};
  assign rise = all_rdy & ~all_rdy_q;
  always_comb begin
    hs = state_q == SEND && s.dout_ready;
    cap = state_q == IDLE && rise;
    state_d = state_q;
    idx_d = idx_q;
    gap_d = gap_q;
    cnt_d = cnt_q;
    wbuf_d = wbuf_q;
    // a rise while busy drops that frame; a new drop beats a simultaneous clear
    ovr_d = (rise && state_q != IDLE) || (ovr_q && !ovr_clr);
    if (cap) begin
      state_d = SEND;
      idx_d = '0;
      wbuf_d = '{res_n0_o0, res_n0_o1, res_n1_o0, res_n1_o1, res_n2_o0, res_n2_o1, res_n3_o0, res_n3_o1};
    end
    if (hs && idx_q == 3'd7) begin
      cnt_d = cnt_q + 8'd1;
      idx_d = '0;
      gap_d = '0;
      state_d = IDLE_GAP > 0 ? GAP : IDLE;
    end else if (hs) idx_d = idx_q + 3'd1;
    if (state_q == GAP) begin
      gap_d = gap_q + 4'd1;
      state_d = gap_q == GAP_LAST ? IDLE : GAP;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      gap_q <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      all_rdy_q <= 1'b0;
      wbuf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      all_rdy_q <= all_rdy;
      wbuf_q <= wbuf_d;
    end
  end
  assign s.dout_valid = state_q == SEND;
  assign s.dout = s.dout_valid ? wbuf_q[idx_q] : '0;
  assign s.dout_idx = s.dout_valid ? idx_q : '0;
  assign s.dout_last = s.dout_valid && idx_q == 3'd7;
`ifdef GNN_SER_PARITY_EN
  assign s.dout_par = s.dout_valid & ^s.dout;
`else
  assign s.dout_par = 1'b0;
`endif
  assign busy = state_q != IDLE;
  assign overrun = ovr_q;
  assign frame_cnt = cnt_q;
endmodule

// File: tb/tb_gnn_result_serializer.sv
// tb_gnn_result_serializer: two serializers (IDLE_GAP 0 and 3) on shared stimulus, checked every cycle against a frame-level model
module tb_gnn_result_serializer;
`ifdef GNN_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int GAPS [2] = '{0, 3};
  logic clk = 1'b0, rst_n = 1'b0, ovr_clr = 1'b0, dready = 1'b1;
  logic [7:0] v = '0;
  logic signed [20:0] r [8];
  logic busy0, busy3, ovr0, ovr3;
  logic [7:0] fc0, fc3;
  int checks = 0, errors = 0, hs0 = 0, hs_start = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  gnn_result_serializer_if if0 ();
  gnn_result_serializer_if if3 ();
  assign if0.dout_ready = dready;
  assign if3.dout_ready = dready;
  always #5 clk = ~clk;
  gnn_result_serializer #(.IDLE_GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .res_n0_o0(r[0]), .res_n0_o1(r[1]), .res_n1_o0(r[2]), .res_n1_o1(r[3]),
    .res_n2_o0(r[4]), .res_n2_o1(r[5]), .res_n3_o0(r[6]), .res_n3_o1(r[7]),
    .rdy_n0_o0(v[0]), .rdy_n0_o1(v[1]), .rdy_n1_o0(v[2]), .rdy_n1_o1(v[3]),
    .rdy_n2_o0(v[4]), .rdy_n2_o1(v[5]), .rdy_n3_o0(v[6]), .rdy_n3_o1(v[7]),
    .ovr_clr(ovr_clr), .busy(busy0), .overrun(ovr0), .frame_cnt(fc0), .s(if0));
  gnn_result_serializer #(.IDLE_GAP(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .res_n0_o0(r[0]), .res_n0_o1(r[1]), .res_n1_o0(r[2]), .res_n1_o1(r[3]),
    .res_n2_o0(r[4]), .res_n2_o1(r[5]), .res_n3_o0(r[6]), .res_n3_o1(r[7]),
    .rdy_n0_o0(v[0]), .rdy_n0_o1(v[1]), .rdy_n1_o0(v[2]), .rdy_n1_o1(v[3]),
    .rdy_n2_o0(v[4]), .rdy_n2_o1(v[5]), .rdy_n3_o0(v[6]), .rdy_n3_o1(v[7]),
    .ovr_clr(ovr_clr), .busy(busy3), .overrun(ovr3), .frame_cnt(fc3), .s(if3));
  // frame-level model: a captured frame, a read position, a countdown of idle cycles
  logic signed [20:0] mw [2][8];
  int mpos [2];
  int mgap [2];
  bit mact [2];
  bit movr [2];
  bit mprev [2];
  bit [7:0] mcnt [2];
  bit m_all, m_rise, m_busy;
  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        mpos[g] = 0; mgap[g] = 0; mact[g] = 0; movr[g] = 0; mprev[g] = 0; mcnt[g] = 0;
      end else begin
        m_all = &v;
        m_rise = m_all && !mprev[g];
        m_busy = mact[g] || mgap[g] > 0;
        mprev[g] = m_all;
        movr[g] = (m_rise && m_busy) || (movr[g] && !ovr_clr);
        if (mact[g]) begin
          if (dready) begin
            if (mpos[g] == 7) begin
              mact[g] = 0;
              mcnt[g] = mcnt[g] + 8'd1;
              mgap[g] = GAPS[g];
            end else mpos[g] = mpos[g] + 1;
          end
        end else if (mgap[g] > 0) mgap[g] = mgap[g] - 1;
        else if (m_rise) begin
          for (int i = 0; i < 8; i++) mw[g][i] = r[i];
          mact[g] = 1;
          mpos[g] = 0;
        end
      end
    end
  end
  always @(posedge clk) if (if0.dout_valid && if0.dout_ready) hs0 = hs0 + 1;
  task automatic chk(input string nm, input int g, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, g, act, exp, $time);
    end
  endtask
  task automatic cmp(input int g, input logic signed [20:0] d, input logic vl, input logic [2:0] ix,
                     input logic ls, input logic pr, input logic bz, input logic ov, input logic [7:0] fc);
    logic signed [20:0] ed;
    ed = mact[g] ? mw[g][mpos[g]] : 21'sd0;
    chk("valid", g, int'(vl), int'(mact[g]));
    chk("dout", g, int'(d), int'(ed));
    chk("idx", g, int'(ix), mact[g] ? mpos[g] : 0);
    chk("last", g, int'(ls), int'(mact[g] && mpos[g] == 7));
    chk("par", g, int'(pr), int'(PAR & ^ed));
    chk("busy", g, int'(bz), int'(mact[g] || mgap[g] > 0));
    chk("overrun", g, int'(ov), int'(movr[g]));
    chk("frame_cnt", g, int'(fc), int'(mcnt[g]));
  endtask
  always @(negedge clk) begin
    cmp(0, if0.dout, if0.dout_valid, if0.dout_idx, if0.dout_last, if0.dout_par, busy0, ovr0, fc0);
    cmp(1, if3.dout, if3.dout_valid, if3.dout_idx, if3.dout_last, if3.dout_par, busy3, ovr3, fc3);
  end
  task automatic wait_last3();
    int n = 0;
    while (!if3.dout_last && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_last_timeout", 1, int'(if3.dout_last), 1);
  endtask
  initial begin
    r = '{default: '0};
    repeat (2) @(negedge clk);
    chk("rst_valid", 0, int'(if0.dout_valid), 0);
    chk("rst_fc", 0, int'(fc0), 0);
    chk("rst_busy", 1, int'(busy3), 0);
    rst_n = 1'b1;
    @(negedge clk);
    r = '{21'sd1, -21'sd2, 21'sd3, -21'sd4, 21'sd5, -21'sd6, 21'sd7, -21'sd8};
    v = '1;
    @(negedge clk);
    chk("f1_first", 0, int'(if0.dout), 1);
    chk("f1_first_valid", 1, int'(if3.dout_valid), 1);
    repeat (7) @(negedge clk);
    chk("f1_w7", 0, int'(if0.dout), -8);
    chk("f1_last", 0, int'(if0.dout_last), 1);
    chk("f1_idx7", 1, int'(if3.dout_idx), 7);
    @(negedge clk);
    chk("f1_drop_valid", 0, int'(if0.dout_valid), 0);
    chk("f1_fc", 0, int'(fc0), 1);
    chk("f1_fc", 1, int'(fc3), 1);
    v = '0;
    repeat (5) @(negedge clk);
    r = '{21'sd100, 21'sd101, 21'sd102, 21'sd103, 21'sd104, 21'sd105, 21'sd106, 21'sd107};
    v = '1;
    hs_start = hs0;
    for (int i = 0; i < 16; i++) begin
      dready = pat[i % 4];
      @(negedge clk);
    end
    dready = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall_handshakes", 0, hs0 - hs_start, 8);
    chk("stall_fc", 0, int'(fc0), 2);
    v = '0;
    @(negedge clk);
    r = '{21'sd10, 21'sd11, 21'sd12, 21'sd13, 21'sd14, 21'sd15, 21'sd16, 21'sd17};
    v = '1;
    repeat (4) @(negedge clk);
    v = '0;
    @(negedge clk);
    v = '1;
    repeat (10) @(negedge clk);
    chk("ovr_set", 0, int'(ovr0), 1);
    chk("ovr_set", 1, int'(ovr3), 1);
    chk("ovr_fc", 0, int'(fc0), 3);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_clr", 0, int'(ovr0), 0);
    chk("ovr_clr", 1, int'(ovr3), 0);
    v = '0;
    @(negedge clk);
    r = '{21'sd20, 21'sd21, 21'sd22, 21'sd23, 21'sd24, 21'sd25, 21'sd26, 21'sd27};
    v = '1;
    wait_last3();
    v = '0;
    @(negedge clk);
    v = '1;
    @(negedge clk);
    chk("gap_rise1_ovr", 1, int'(ovr3), 1);
    chk("gap0_recapture", 0, int'(if0.dout_valid), 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    repeat (12) @(negedge clk);
    v = '0;
    @(negedge clk);
    v = '1;
    wait_last3();
    v = '0;
    repeat (4) @(negedge clk);
    v = '1;
    @(negedge clk);
    chk("gap_rise4_valid", 1, int'(if3.dout_valid), 1);
    chk("gap_rise4_ovr", 1, int'(ovr3), 0);
    repeat (12) @(negedge clk);
    r = '{21'sh000007, 21'sh000003, 21'sd5, 21'sd6, 21'sd8, 21'sd9, 21'sd11, 21'sd12};
    v = '0;
    @(negedge clk);
    v = '1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 0, int'(if0.dout_valid), 0);
    chk("rst_mid_dout", 0, int'(if0.dout), 0);
    chk("rst_mid_busy", 1, int'(busy3), 0);
    chk("rst_mid_fc", 0, int'(fc0), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_dout7", 0, int'(if0.dout), 7);
    chk("rel_idx0", 0, int'(if0.dout_idx), 0);
    chk("par7", 0, int'(if0.dout_par), int'(PAR));
    @(negedge clk);
    chk("rel_dout3", 0, int'(if0.dout), 3);
    chk("par3", 0, int'(if0.dout_par), 0);
    repeat (12) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
